cpa_sum_accumulator: RTL and testbench

Downstream consumer of the 4-bit carry-propagate adder (`addercpa4`). It captures a frame of COUNT adder sums presented with a valid strobe and accumulates them into a wider register with a sticky overflow flag. It then presents the frame total on a valid/ready output handshake. It turns the adder's combinational 4-bit result stream into a registered, framed total for the next stage.

---
 rtl/cpa_sum_accumulator_if.sv | 25 ++
 rtl/cpa_sum_accumulator.sv | 77 +++++++
 tb/tb_cpa_sum_accumulator.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpa_sum_accumulator_if.sv
// Handshake bundle between the adder-sum producer, the accumulator and the downstream consumer.
// Valid/ready: a total transfers on the rising edge where acc_valid and acc_ready are both high.
interface cpa_sum_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic [3:0]       sum_in;
    logic             sum_valid;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             busy;
    logic             ovf;
    logic [1:0]       state_dbg;

    modport master (
        output start, sum_in, sum_valid, acc_ready,
        input  acc_out, acc_valid, busy, ovf, state_dbg
    );

    modport slave (
        input  start, sum_in, sum_valid, acc_ready,
        output acc_out, acc_valid, busy, ovf, state_dbg
    );
endinterface

// File: rtl/cpa_sum_accumulator.sv
// Accumulates a frame of COUNT 4-bit adder sums into an ACC_W-bit total with a sticky
// overflow flag, then offers the total on a valid/ready handshake.
module cpa_sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cpa_sum_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(COUNT - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;
    logic             acc_valid_o, busy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (bus.sum_valid && (cnt_q == LAST_IDX)) state_d = DONE;
            DONE:    if (bus.acc_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The extra top bit of sum_ext is the carry out of the accumulator width.
    always_comb begin
        sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(bus.sum_in);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if ((state_q == IDLE) && bus.start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == ACCUM) && bus.sum_valid) begin
            acc_d = sum_ext[ACC_W-1:0];
            cnt_d = cnt_q + 4'd1;
            ovf_d = ovf_q | sum_ext[ACC_W];
        end
    end

    always_comb begin
        acc_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    assign bus.acc_out   = acc_q;
    assign bus.acc_valid = acc_valid_o;
    assign bus.busy      = busy_o;
    assign bus.ovf       = ovf_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_cpa_sum_accumulator.sv
// Bench for cpa_sum_accumulator: three instances (8-bit, 5-bit and COUNT=1) share one
// stimulus stream and are checked against frame totals computed with plain arithmetic.
module tb_cpa_sum_accumulator;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] sum_in;
    logic       sum_valid;
    logic       acc_ready;

    int n_checks;
    int n_pass;

    logic [3:0] frame[$];
    logic [7:0] exp_q[$];

    cpa_sum_accumulator_if #(.ACC_W(8)) bus_a ();
    cpa_sum_accumulator_if #(.ACC_W(5)) bus_b ();
    cpa_sum_accumulator_if #(.ACC_W(8)) bus_c ();

    assign bus_a.start = start;  assign bus_a.sum_in = sum_in;
    assign bus_a.sum_valid = sum_valid;  assign bus_a.acc_ready = acc_ready;
    assign bus_b.start = start;  assign bus_b.sum_in = sum_in;
    assign bus_b.sum_valid = sum_valid;  assign bus_b.acc_ready = acc_ready;
    assign bus_c.start = start;  assign bus_c.sum_in = sum_in;
    assign bus_c.sum_valid = sum_valid;  assign bus_c.acc_ready = acc_ready;

    cpa_sum_accumulator #(.COUNT(4), .ACC_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    cpa_sum_accumulator #(.COUNT(4), .ACC_W(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    cpa_sum_accumulator #(.COUNT(1), .ACC_W(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver: one full frame on the shared inputs ----------------
    task automatic send_frame(input int gap_lo, input int gap_hi, input int hold, input bit collide);
        int total;
        int part;
        int gap;
        logic [7:0] got;
        total = 0;
        foreach (frame[i]) total += int'(frame[i]);
        exp_q.push_back(8'(total));

        acc_ready = 1'b0;
        start     = 1'b1;
        sum_valid = collide;
        sum_in    = 4'd9;
        tick();
        start     = 1'b0;
        n_checks++;
        if (bus_a.busy !== 1'b1 || bus_a.acc_out !== 8'h00 || bus_a.acc_valid !== 1'b0)
            $display("FAIL start_busy: busy=%b acc_out=%0h acc_valid=%b, need busy=1 acc_out=0 acc_valid=0",
                     bus_a.busy, bus_a.acc_out, bus_a.acc_valid);
        else n_pass++;

        part = 0;
        for (int i = 0; i < frame.size(); i++) begin
            gap = int'($urandom_range(gap_hi, gap_lo));
            for (int g = 0; g < gap; g++) begin
                sum_valid = 1'b0;
                sum_in    = 4'($urandom_range(15, 0));
                tick();
                n_checks++;
                if (bus_a.acc_out !== 8'(part) || bus_a.acc_valid !== 1'b0)
                    $display("FAIL gap_hold: acc_out=%0h acc_valid=%b, need acc_out=%0h acc_valid=0",
                             bus_a.acc_out, bus_a.acc_valid, 8'(part));
                else n_pass++;
            end
            sum_valid = 1'b1;
            sum_in    = frame[i];
            tick();
            part += int'(frame[i]);
            if (i < frame.size() - 1) begin
                n_checks++;
                if (bus_a.acc_out !== 8'(part) || bus_a.acc_valid !== 1'b0)
                    $display("FAIL accum_step: acc_out=%0h acc_valid=%b, need acc_out=%0h acc_valid=0",
                             bus_a.acc_out, bus_a.acc_valid, 8'(part));
                else n_pass++;
            end
            if (i == 0) begin
                n_checks++;
                if (bus_c.acc_valid !== 1'b1 || bus_c.acc_out !== 8'(frame[0]))
                    $display("FAIL count1_done: acc_valid=%b acc_out=%0h, need acc_valid=1 acc_out=%0h",
                             bus_c.acc_valid, bus_c.acc_out, 8'(frame[0]));
                else n_pass++;
            end
        end
        sum_valid = 1'b0;

        n_checks++;
        if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 8'(total) || bus_a.ovf !== (total >= 256))
            $display("FAIL done_a: acc_valid=%b acc_out=%0h ovf=%b, need acc_valid=1 acc_out=%0h ovf=%b",
                     bus_a.acc_valid, bus_a.acc_out, bus_a.ovf, 8'(total), total >= 256);
        else n_pass++;
        n_checks++;
        if (bus_b.acc_valid !== 1'b1 || bus_b.acc_out !== 5'(total) || bus_b.ovf !== (total >= 32))
            $display("FAIL done_b: acc_valid=%b acc_out=%0d ovf=%b, need acc_valid=1 acc_out=%0d ovf=%b",
                     bus_b.acc_valid, bus_b.acc_out, bus_b.ovf, total % 32, total >= 32);
        else n_pass++;

        // Backpressure: a start pulse while the total waits must be ignored.
        for (int h = 0; h < hold; h++) begin
            acc_ready = 1'b0;
            start     = (h == hold / 2);
            tick();
            n_checks++;
            if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 8'(total))
                $display("FAIL bp_hold: acc_valid=%b acc_out=%0h, need acc_valid=1 acc_out=%0h",
                         bus_a.acc_valid, bus_a.acc_out, 8'(total));
            else n_pass++;
        end

        acc_ready = 1'b1;
        start     = 1'b1;
        got       = bus_a.acc_out;
        tick();
        start     = 1'b0;
        acc_ready = 1'b0;
        n_checks++;
        if (got !== exp_q[0])
            $display("FAIL scoreboard: transferred total=%0h, need %0h", got, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        n_checks++;
        if (bus_a.acc_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.acc_out !== 8'(total) ||
            bus_c.acc_valid !== 1'b0 || bus_c.busy !== 1'b0)
            $display("FAIL handover: a.valid=%b a.busy=%b a.acc_out=%0h c.valid=%b c.busy=%b, need 0 0 %0h 0 0",
                     bus_a.acc_valid, bus_a.busy, bus_a.acc_out, bus_c.acc_valid, bus_c.busy, 8'(total));
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.acc_out !== 8'h00 || bus_a.acc_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.ovf !== 1'b0)
            $display("FAIL reset_state: acc_out=%0h valid=%b busy=%b ovf=%b, need all 0",
                     bus_a.acc_out, bus_a.acc_valid, bus_a.busy, bus_a.ovf);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0 || bus_c.busy !== 1'b0)
            $display("FAIL idle_after_reset: busy a/b/c=%b%b%b, need 000", bus_a.busy, bus_b.busy, bus_c.busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        frame = '{4'd6, 4'd10, 4'd2, 4'd12};
        send_frame(0, 0, 0, 1'b0);
        n_checks++;
        if (bus_a.acc_out !== 8'h1E || bus_a.ovf !== 1'b0)
            $display("FAIL basic_total: acc_out=%0h ovf=%b, need 1e 0", bus_a.acc_out, bus_a.ovf);
        else n_pass++;
    endtask

    task automatic test_overflow();
        frame = '{4'd15, 4'd15, 4'd15, 4'd15};
        send_frame(0, 0, 0, 1'b0);
        n_checks++;
        if (bus_b.acc_out !== 5'd28 || bus_b.ovf !== 1'b1)
            $display("FAIL ovf_frame: acc_out=%0d ovf=%b, need 28 1", bus_b.acc_out, bus_b.ovf);
        else n_pass++;
        frame = '{4'd1, 4'd1, 4'd1, 4'd1};
        send_frame(0, 0, 0, 1'b0);
        n_checks++;
        if (bus_b.acc_out !== 5'd4 || bus_b.ovf !== 1'b0)
            $display("FAIL ovf_cleared: acc_out=%0d ovf=%b, need 4 0", bus_b.acc_out, bus_b.ovf);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        frame = '{4'd6, 4'd10, 4'd2, 4'd12};
        send_frame(3, 3, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        frame = '{4'd6, 4'd10, 4'd2, 4'd12};
        send_frame(0, 0, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start     = 1'b0;
        sum_valid = 1'b1;
        sum_in    = 4'd6;
        tick();
        sum_in    = 4'd10;
        tick();
        sum_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_a.acc_out !== 8'h00 || bus_a.busy !== 1'b0 || bus_a.acc_valid !== 1'b0 || bus_c.acc_valid !== 1'b0)
            $display("FAIL reset_async: acc_out=%0h busy=%b valid=%b c.valid=%b, need 0 0 0 0",
                     bus_a.acc_out, bus_a.busy, bus_a.acc_valid, bus_c.acc_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_basic();
    endtask

    task automatic test_collision();
        frame = '{4'd1, 4'd2, 4'd3, 4'd4};
        send_frame(0, 0, 0, 1'b1);
        n_checks++;
        if (bus_a.acc_out !== 8'd10)
            $display("FAIL collision_total: acc_out=%0d, need 10", bus_a.acc_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 20; f++) begin
            frame.delete();
            for (int k = 0; k < 4; k++) frame.push_back(4'($urandom_range(15, 0)));
            send_frame(0, 2, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        sum_in    = 4'd0;
        sum_valid = 1'b0;
        acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d totals never transferred, need 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
